// File: rtl/store_stage_pkg.sv
// Shared encodings for the store path: store types, address-region nibbles
// and the IO handshake state encoding.
package store_stage_pkg;

  localparam logic [1:0] ST_SB  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SW  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  localparam logic [3:0] REG_DMEM = 4'h1;
  localparam logic [3:0] REG_IMEM = 4'h2;
  localparam logic [3:0] REG_BOTH = 4'h3;
  localparam logic [3:0] REG_IO   = 4'h8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

endpackage

// File: rtl/store_stage_align.sv
// Lane alignment for stores: replicates the source bytes across lanes,
// builds the byte strobes and flags addresses that the store size cannot use.
module store_align
  import store_stage_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  strb_o,
  output logic        misaligned_o
);

  always_comb begin
    wdata_o      = data_i;
    strb_o       = 4'b0000;
    misaligned_o = 1'b0;
    case (st_type_i)
      ST_SB: begin
        wdata_o = {4{data_i[7:0]}};
        strb_o  = 4'b0001 << addr_lo_i;
      end
      ST_SH: begin
        wdata_o      = {2{data_i[15:0]}};
        strb_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      ST_SW: begin
        strb_o       = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        strb_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/store_stage.sv
// Store-side write path: aligns EXE-stage stores, registers DMEM/IMEM write
// ports and feeds IO stores through a one-entry valid/ready buffer.
module store_stage
  import store_stage_pkg::*;
#(
  parameter int DMEM_AW = 14,
  parameter int IMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  input  logic [1:0]         st_type,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic               io_wvalid,
  output logic [31:0]        io_waddr,
  output logic [31:0]        io_wdata,
  output logic [3:0]         io_wstrb,
  input  logic               io_wready,
  output logic               stall,
  output logic               misalign
);

  logic [31:0] al_data;
  logic [3:0]  al_strb;
  logic        al_mis;

  store_align u_align (
    .st_type_i    (st_type),
    .addr_lo_i    (st_addr[1:0]),
    .data_i       (st_data),
    .wdata_o      (al_data),
    .strb_o       (al_strb),
    .misaligned_o (al_mis)
  );

  logic [3:0] region;
  logic       to_dmem, to_imem, to_io;
  logic       accept, write_ok, io_load;

  logic [0:0]         state_q, state_d;
  logic [3:0]         dmem_we_q, dmem_we_d, imem_we_q, imem_we_d;
  logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        dmem_din_q, dmem_din_d, imem_din_q, imem_din_d;
  logic [31:0]        io_waddr_q, io_waddr_d, io_wdata_q, io_wdata_d;
  logic [3:0]         io_wstrb_q, io_wstrb_d;
  logic               misalign_q, misalign_d;

  assign region  = st_addr[31:28];
  assign to_dmem = (region == REG_DMEM) || (region == REG_BOTH);
  assign to_imem = (region == REG_IMEM) || (region == REG_BOTH);
  assign to_io   = (region == REG_IO);

  // Only state and the live handshake feed stall, so it never loops through outputs.
  assign stall    = st_valid && to_io && (state_q == S_PEND) && !io_wready;
  assign accept   = st_valid && !stall;
  assign write_ok = accept && !al_mis && (st_type != ST_RSV);
  assign io_load  = write_ok && to_io;

  always_comb begin
    dmem_we_d   = (write_ok && to_dmem) ? al_strb : 4'b0000;
    imem_we_d   = (write_ok && to_imem) ? al_strb : 4'b0000;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;
    imem_addr_d = imem_addr_q;
    imem_din_d  = imem_din_q;
    if (write_ok && to_dmem) begin
      dmem_addr_d = st_addr[DMEM_AW+1:2];
      dmem_din_d  = al_data;
    end
    if (write_ok && to_imem) begin
      imem_addr_d = st_addr[IMEM_AW+1:2];
      imem_din_d  = al_data;
    end
    misalign_d = accept && al_mis;
  end

  // A completing handshake and a new IO store may coincide: reload and stay PEND.
  always_comb begin
    state_d    = state_q;
    io_waddr_d = io_waddr_q;
    io_wdata_d = io_wdata_q;
    io_wstrb_d = io_wstrb_q;
    if (io_load) begin
      state_d    = S_PEND;
      io_waddr_d = st_addr;
      io_wdata_d = al_data;
      io_wstrb_d = al_strb;
    end else if ((state_q == S_PEND) && io_wready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dmem_we_q   <= '0;
      imem_we_q   <= '0;
      dmem_addr_q <= '0;
      imem_addr_q <= '0;
      dmem_din_q  <= '0;
      imem_din_q  <= '0;
      io_waddr_q  <= '0;
      io_wdata_q  <= '0;
      io_wstrb_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dmem_we_q   <= dmem_we_d;
      imem_we_q   <= imem_we_d;
      dmem_addr_q <= dmem_addr_d;
      imem_addr_q <= imem_addr_d;
      dmem_din_q  <= dmem_din_d;
      imem_din_q  <= imem_din_d;
      io_waddr_q  <= io_waddr_d;
      io_wdata_q  <= io_wdata_d;
      io_wstrb_q  <= io_wstrb_d;
      misalign_q  <= misalign_d;
    end
  end

  assign dmem_we   = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_din  = dmem_din_q;
  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_din  = imem_din_q;
  assign io_wvalid = (state_q == S_PEND);
  assign io_waddr  = io_waddr_q;
  assign io_wdata  = io_wdata_q;
  assign io_wstrb  = io_wstrb_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_store_stage.sv
// Directed bench for store_stage: one task per scenario, inline comparisons
// against hand-computed values, one summary line at the end.
module tb_store_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [3:0]  imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic        io_wvalid;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_wready;
  logic        stall;
  logic        misalign;

  int nvec = 0;
  int nerr = 0;

  store_stage #(.DMEM_AW(14), .IMEM_AW(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_type   (st_type),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .io_wvalid (io_wvalid),
    .io_waddr  (io_waddr),
    .io_wdata  (io_wdata),
    .io_wstrb  (io_wstrb),
    .io_wready (io_wready),
    .stall     (stall),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; io_wready = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    nvec++; if (dmem_we !== 4'b0) begin nerr++; $display("FAIL reset_dmem_we got %b exp 0000", dmem_we); end
    nvec++; if (imem_we !== 4'b0) begin nerr++; $display("FAIL reset_imem_we got %b exp 0000", imem_we); end
    nvec++; if (io_wvalid !== 1'b0) begin nerr++; $display("FAIL reset_io_wvalid got %b exp 0", io_wvalid); end
    nvec++; if (io_wstrb !== 4'b0) begin nerr++; $display("FAIL reset_io_wstrb got %b exp 0000", io_wstrb); end
    nvec++; if (misalign !== 1'b0) begin nerr++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    nvec++; if (io_waddr !== 32'h0) begin nerr++; $display("FAIL reset_io_waddr got %h exp 0", io_waddr); end
    $display("reset: vectors=%0d miscompares=%0d", nvec, nerr);
  endtask

  task automatic test_sb();
    drive(1'b1, 2'd0, 32'h1000_0003, 32'hAABB_CCDD);
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (dmem_we !== 4'b1000) begin nerr++; $display("FAIL sb_dmem_we got %b exp 1000", dmem_we); end
    nvec++; if (dmem_din !== 32'hDDDD_DDDD) begin nerr++; $display("FAIL sb_dmem_din got %h exp DDDDDDDD", dmem_din); end
    nvec++; if (dmem_addr !== 14'd0) begin nerr++; $display("FAIL sb_dmem_addr got %0d exp 0", dmem_addr); end
    nvec++; if (imem_we !== 4'b0) begin nerr++; $display("FAIL sb_imem_we got %b exp 0000", imem_we); end
    cyc();
    nvec++; if (dmem_we !== 4'b0) begin nerr++; $display("FAIL sb_one_cycle got %b exp 0000", dmem_we); end
    $display("sb 0x10000003: dmem_we=%b din=%h", 4'b1000, 32'hDDDD_DDDD);
  endtask

  task automatic test_sh();
    drive(1'b1, 2'd1, 32'h3000_0006, 32'h0000_1234);
    cyc();
    drive(1'b1, 2'd1, 32'h1000_0001, 32'h0000_5678);
    nvec++; if (dmem_we !== 4'b1100) begin nerr++; $display("FAIL sh_dmem_we got %b exp 1100", dmem_we); end
    nvec++; if (imem_we !== 4'b1100) begin nerr++; $display("FAIL sh_imem_we got %b exp 1100", imem_we); end
    nvec++; if (dmem_din !== 32'h1234_1234) begin nerr++; $display("FAIL sh_dmem_din got %h exp 12341234", dmem_din); end
    nvec++; if (imem_din !== 32'h1234_1234) begin nerr++; $display("FAIL sh_imem_din got %h exp 12341234", imem_din); end
    nvec++; if (dmem_addr !== 14'd1) begin nerr++; $display("FAIL sh_dmem_addr got %0d exp 1", dmem_addr); end
    nvec++; if (imem_addr !== 14'd1) begin nerr++; $display("FAIL sh_imem_addr got %0d exp 1", imem_addr); end
    nvec++; if (misalign !== 1'b0) begin nerr++; $display("FAIL sh_no_misalign got %b exp 0", misalign); end
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (dmem_we !== 4'b0) begin nerr++; $display("FAIL sh_mis_dmem_we got %b exp 0000", dmem_we); end
    nvec++; if (misalign !== 1'b1) begin nerr++; $display("FAIL sh_mis_pulse got %b exp 1", misalign); end
    cyc();
    nvec++; if (misalign !== 1'b0) begin nerr++; $display("FAIL sh_mis_one_cycle got %b exp 0", misalign); end
    $display("sh 0x30000006 both targets, sh 0x10000001 misaligned");
  endtask

  task automatic test_io_stall();
    io_wready = 1'b0;
    drive(1'b1, 2'd2, 32'h8000_0008, 32'hCAFE_F00D);
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL io_valid1 got %b exp 1", io_wvalid); end
    nvec++; if (io_waddr !== 32'h8000_0008) begin nerr++; $display("FAIL io_addr1 got %h exp 80000008", io_waddr); end
    nvec++; if (io_wdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL io_data1 got %h exp CAFEF00D", io_wdata); end
    nvec++; if (io_wstrb !== 4'b1111) begin nerr++; $display("FAIL io_strb1 got %b exp 1111", io_wstrb); end
    cyc();
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL io_valid2 got %b exp 1", io_wvalid); end
    drive(1'b1, 2'd0, 32'h8000_0001, 32'h0000_0055);
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL io_stall_busy got %b exp 1", stall); end
    cyc();
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL io_valid3 got %b exp 1", io_wvalid); end
    nvec++; if (io_wdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL io_data3_stable got %h exp CAFEF00D", io_wdata); end
    nvec++; if (io_waddr !== 32'h8000_0008) begin nerr++; $display("FAIL io_addr3_stable got %h exp 80000008", io_waddr); end
    io_wready = 1'b1;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL io_stall_release got %b exp 0", stall); end
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL io_b2b_valid got %b exp 1", io_wvalid); end
    nvec++; if (io_waddr !== 32'h8000_0001) begin nerr++; $display("FAIL io_b2b_addr got %h exp 80000001", io_waddr); end
    nvec++; if (io_wdata !== 32'h5555_5555) begin nerr++; $display("FAIL io_b2b_data got %h exp 55555555", io_wdata); end
    nvec++; if (io_wstrb !== 4'b0010) begin nerr++; $display("FAIL io_b2b_strb got %b exp 0010", io_wstrb); end
    cyc();
    io_wready = 1'b0;
    nvec++; if (io_wvalid !== 1'b0) begin nerr++; $display("FAIL io_drain got %b exp 0", io_wvalid); end
    $display("io sw 0x80000008 held 3 cycles, sb 0x80000001 back-to-back");
  endtask

  task automatic test_mixed();
    io_wready = 1'b0;
    drive(1'b1, 2'd2, 32'h8000_0000, 32'h1111_1111);
    cyc();
    drive(1'b1, 2'd2, 32'h1000_0010, 32'hDEAD_BEEF);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL mix_no_stall got %b exp 0", stall); end
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (dmem_we !== 4'b1111) begin nerr++; $display("FAIL mix_dmem_we got %b exp 1111", dmem_we); end
    nvec++; if (dmem_addr !== 14'd4) begin nerr++; $display("FAIL mix_dmem_addr got %0d exp 4", dmem_addr); end
    nvec++; if (dmem_din !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL mix_dmem_din got %h exp DEADBEEF", dmem_din); end
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL mix_io_valid got %b exp 1", io_wvalid); end
    nvec++; if (io_waddr !== 32'h8000_0000) begin nerr++; $display("FAIL mix_io_addr got %h exp 80000000", io_waddr); end
    io_wready = 1'b1;
    cyc();
    io_wready = 1'b0;
    nvec++; if (io_wvalid !== 1'b0) begin nerr++; $display("FAIL mix_io_done got %b exp 0", io_wvalid); end
    $display("mixed: dmem sw 0x10000010 during io pending");
  endtask

  task automatic test_dropped();
    drive(1'b1, 2'd2, 32'h4000_0000, 32'h1234_5678);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL drop_stall got %b exp 0", stall); end
    cyc();
    drive(1'b1, 2'd3, 32'h1000_0000, 32'h1234_5678);
    nvec++; if ({dmem_we, imem_we, io_wvalid, misalign} !== 10'b0) begin nerr++;
      $display("FAIL drop_region got we=%b/%b v=%b m=%b exp 0", dmem_we, imem_we, io_wvalid, misalign); end
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if ({dmem_we, imem_we, io_wvalid, misalign} !== 10'b0) begin nerr++;
      $display("FAIL drop_rsv got we=%b/%b v=%b m=%b exp 0", dmem_we, imem_we, io_wvalid, misalign); end
    $display("dropped: region 4 and st_type=3");
  endtask

  task automatic test_reset_mid();
    io_wready = 1'b0;
    drive(1'b1, 2'd2, 32'h8000_0004, 32'h7777_7777);
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (io_wvalid !== 1'b1) begin nerr++; $display("FAIL rmid_pending got %b exp 1", io_wvalid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nvec++; if (io_wvalid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b exp 0", io_wvalid); end
    nvec++; if (io_wstrb !== 4'b0) begin nerr++; $display("FAIL rmid_strb got %b exp 0000", io_wstrb); end
    drive(1'b1, 2'd2, 32'h8000_000C, 32'h0BAD_F00D);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rmid_stall got %b exp 0", stall); end
    cyc();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    nvec++; if (io_wvalid !== 1'b1 || io_waddr !== 32'h8000_000C || io_wdata !== 32'h0BAD_F00D) begin nerr++;
      $display("FAIL rmid_next got v=%b a=%h d=%h exp 1/8000000C/0BADF00D", io_wvalid, io_waddr, io_wdata); end
    io_wready = 1'b1;
    cyc();
    nvec++; if (io_wvalid !== 1'b0) begin nerr++; $display("FAIL rmid_drain got %b exp 0", io_wvalid); end
    $display("reset while io pending, then io sw 0x8000000C");
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_io_stall();
    test_mixed();
    test_dropped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
